// File: rtl/delay_arbiter_pkg.sv
// Shared types and helpers for the round-robin delay-line arbiter.
package delay_arbiter_pkg;

  // The control-lane id field is sized for the largest supported requester count.
  localparam int unsigned MaxRequesters = 32;
  localparam int unsigned MaxIdWidth    = 5;

  typedef struct packed {
    logic                  valid;
    logic [MaxIdWidth-1:0] id;
  } rsp_ctl_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Index of the first set bit of vec[n-1:0] at or after start, wrapping; n when none is set.
  function automatic int unsigned rr_first(input logic [MaxRequesters-1:0] vec,
                                           input int unsigned n,
                                           input int unsigned start);
    int unsigned res;
    int unsigned idx;
    logic [4:0]  sel;
    res = n;
    for (int unsigned k = MaxRequesters; k > 0; k--) begin
      if (k <= n) begin
        idx = (start + k - 1) % n;
        sel = idx[4:0];
        if (vec[sel]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/delay_arbiter_delay.sv
// Fixed-latency payload shift line; no reset since contents are qualified by the control lane.
module Delay #(
  parameter int unsigned Depth = 3,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk_i) begin
    stage_q[0] <= d_i;
    for (int i = 1; i < Depth; i++) begin
      stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin arbiter feeding a shared fixed-latency line, with per-requester credit limits.
module delay_arbiter import delay_arbiter_pkg::*; #(
  parameter  int unsigned Requesters = 4,
  parameter  int unsigned Depth      = 3,
  parameter  int unsigned Width      = 8,
  parameter  int unsigned Credits    = 2,
  localparam int unsigned IdWidth    = id_width(Requesters)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        ENABLE,
  input  logic [Requesters-1:0]       REQ_VALID,
  input  logic [Requesters*Width-1:0] REQ_DATA,
  output logic [Requesters-1:0]       REQ_READY,
  output logic                        RSP_VALID,
  output logic [IdWidth-1:0]          RSP_ID,
  output logic [Width-1:0]            RSP_DATA,
  output logic                        IDLE
);

  localparam int unsigned CntWidth = $clog2(Credits + 1);

  logic [IdWidth-1:0]  last_q, last_d;
  logic [CntWidth-1:0] cnt_q [Requesters];
  logic [CntWidth-1:0] cnt_d [Requesters];
  rsp_ctl_t            ctl_q [Depth];
  rsp_ctl_t            ctl_in, ret;
  logic [Requesters-1:0] ret_hit, elig;
  logic [Width-1:0]    data_in;
  int unsigned         start, win;
  logic                grant;

  always_comb begin
    ret     = ctl_q[Depth-1];
    ret_hit = '0;
    elig    = '0;
    for (int unsigned i = 0; i < Requesters; i++) begin
      ret_hit[i] = ret.valid && (ret.id == MaxIdWidth'(i));
      // A credit returning this cycle is usable immediately.
      elig[i]    = REQ_VALID[i] && ENABLE && !RST &&
                   ((cnt_q[i] < CntWidth'(Credits)) || ret_hit[i]);
    end
    start = (int'(last_q) + 1) % Requesters;
    win   = rr_first(MaxRequesters'(elig), Requesters, start);
    grant = (win < Requesters);

    REQ_READY = '0;
    data_in   = '0;
    for (int unsigned i = 0; i < Requesters; i++) begin
      REQ_READY[i] = grant && (win == i);
      if (REQ_READY[i]) data_in = REQ_DATA[i*Width +: Width];
    end

    ctl_in       = '0;
    ctl_in.valid = grant;
    if (grant) ctl_in.id = MaxIdWidth'(win);
    last_d = grant ? IdWidth'(win) : last_q;

    for (int unsigned i = 0; i < Requesters; i++) begin
      cnt_d[i] = cnt_q[i];
      if (REQ_READY[i] && !ret_hit[i]) cnt_d[i] = cnt_q[i] + CntWidth'(1);
      else if (!REQ_READY[i] && ret_hit[i]) cnt_d[i] = cnt_q[i] - CntWidth'(1);
    end

    IDLE = 1'b1;
    for (int d = 0; d < Depth; d++) begin
      if (ctl_q[d].valid) IDLE = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q <= IdWidth'(Requesters - 1);
      for (int i = 0; i < Requesters; i++) cnt_q[i] <= '0;
      for (int d = 0; d < Depth; d++) ctl_q[d] <= '0;
    end else begin
      last_q <= last_d;
      for (int i = 0; i < Requesters; i++) cnt_q[i] <= cnt_d[i];
      ctl_q[0] <= ctl_in;
      for (int d = 1; d < Depth; d++) ctl_q[d] <= ctl_q[d-1];
    end
  end

  assign RSP_VALID = ret.valid;
  assign RSP_ID    = ret.id[IdWidth-1:0];

  Delay #(
    .Depth(Depth),
    .Width(Width)
  ) u_payload (
    .clk_i(CLK),
    .d_i  (data_in),
    .q_o  (RSP_DATA)
  );

endmodule

// File: tb/tb_delay_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts grants, idle and tagged responses.
module tb_delay_arbiter;

  localparam int NReq  = 4;
  localparam int Dep   = 3;
  localparam int W     = 8;
  localparam int NCred = 2;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            ENABLE = 1'b0;
  logic [NReq-1:0] REQ_VALID = '0;
  logic [NReq*W-1:0] REQ_DATA = '0;
  logic [NReq-1:0] REQ_READY;
  logic            RSP_VALID;
  logic [1:0]      RSP_ID;
  logic [W-1:0]    RSP_DATA;
  logic            IDLE;

  delay_arbiter #(
    .Requesters(NReq),
    .Depth     (Dep),
    .Width     (W),
    .Credits   (NCred)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ENABLE   (ENABLE),
    .REQ_VALID(REQ_VALID),
    .REQ_DATA (REQ_DATA),
    .REQ_READY(REQ_READY),
    .RSP_VALID(RSP_VALID),
    .RSP_ID   (RSP_ID),
    .RSP_DATA (RSP_DATA),
    .IDLE     (IDLE)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    int         due;
  } ent_t;

  // Reference model state
  int   cnt [NReq];
  int   last;
  ent_t infl[$];
  bit   rst_pending;

  // Scoreboard queues
  ent_t            exp_rsp[$];
  logic [NReq-1:0] exp_ready_q[$];
  logic            exp_idle_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit checking = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NReq; i++) cnt[i] = 0;
    last = NReq - 1;
    infl.delete();
    exp_rsp.delete();
    rst_pending = 0;
  endtask

  // One clock cycle of stimulus plus the model's prediction for it.
  task automatic step(input bit rst, input bit en, input logic [NReq-1:0] v,
                      input logic [NReq*W-1:0] data);
    int   ret_id, win, i;
    ent_t e;
    @(posedge CLK);
    #1;
    if (rst_pending) model_reset();
    cyc++;
    RST = rst;
    ENABLE = en;
    REQ_VALID = v;
    REQ_DATA = data;
    while (infl.size() > 0 && infl[0].due < cyc) void'(infl.pop_front());
    exp_idle_q.push_back(infl.size() == 0);
    ret_id = -1;
    if (infl.size() > 0 && infl[0].due == cyc) ret_id = int'(infl[0].id);
    win = -1;
    if (!rst) begin
      for (int k = 1; k <= NReq && win < 0; k++) begin
        i = (last + k) % NReq;
        if (v[i] && en && (cnt[i] < NCred || ret_id == i)) win = i;
      end
    end
    exp_ready_q.push_back(win >= 0 ? NReq'(1) << win : NReq'(0));
    if (ret_id >= 0) cnt[ret_id]--;
    if (win >= 0) begin
      cnt[win]++;
      last = win;
      e.id = 2'(win);
      e.data = data[win*W +: W];
      e.due = cyc + Dep;
      infl.push_back(e);
      exp_rsp.push_back(e);
    end
    rst_pending = rst;
  endtask

  always @(negedge CLK) begin
    ent_t e;
    if (checking) begin
      if (exp_ready_q.size() > 0) begin
        chk("req_ready", 32'(REQ_READY), 32'(exp_ready_q.pop_front()));
        chk("idle", 32'(IDLE), 32'(exp_idle_q.pop_front()));
      end
      if (RSP_VALID === 1'b1 || (exp_rsp.size() > 0 && exp_rsp[0].due == cyc)) begin
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", 32'(RSP_VALID), 32'd0);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_valid", 32'(RSP_VALID), 32'd1);
          if (RSP_VALID === 1'b1) begin
            chk("rsp_cycle", 32'(cyc), 32'(e.due));
            chk("rsp_id", 32'(RSP_ID), 32'(e.id));
            chk("rsp_data", 32'(RSP_DATA), 32'(e.data));
          end
        end
      end
    end
  end

  initial begin
    logic [NReq*W-1:0] rd;
    logic [NReq-1:0]   rv;
    bit                rr, re;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    checking = 1;

    // Single request from requester 0
    step(0, 1, 4'b0001, 32'h0000005A);
    repeat (4) step(0, 1, 4'b0000, 32'h0);
    // All requesters, unique data
    repeat (8) step(0, 1, 4'b1111, 32'hD4C3B2A1);
    repeat (4) step(0, 1, 4'b0000, 32'h0);
    // Single requester limited by credits
    repeat (8) step(0, 1, 4'b0100, 32'h00770000);
    repeat (4) step(0, 1, 4'b0000, 32'h0);
    repeat (8) step(0, 1, 4'b0010, 32'h00003300);
    repeat (4) step(0, 1, 4'b0000, 32'h0);
    // Drain with ENABLE low
    repeat (3) step(0, 1, 4'b1111, 32'h44332211);
    repeat (5) step(0, 0, 4'b1111, 32'h44332211);
    // Reset with requests in flight
    repeat (2) step(0, 1, 4'b1111, 32'h88776655);
    step(1, 0, 4'b0000, 32'h0);
    step(0, 1, 4'b0000, 32'h0);
    repeat (4) step(0, 1, 4'b1111, 32'hCCBBAA99);
    repeat (4) step(0, 1, 4'b0000, 32'h0);

    for (int n = 0; n < 1500; n++) begin
      rr = ($urandom_range(63) == 0);
      re = ($urandom_range(7) != 0);
      rv = rr ? 4'b0000 : 4'($urandom);
      rd = $urandom;
      step(rr, re, rv, rd);
    end
    repeat (Dep + 3) step(0, 1, 4'b0000, 32'h0);
    @(negedge CLK);
    #1;
    chk("rsp_left_over", 32'(exp_rsp.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
